// File: rtl/cg_mem_pkg.sv
// Shared types for the cg memory interface endpoints.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cg_mem_pkg;

  // Which channel wins the single SRAM port when both request together.
  typedef enum logic {
    CG_PRIO_READ  = 1'b0,
    CG_PRIO_WRITE = 1'b1
  } cg_mem_prio_e;

  // Deepest SRAM read pipeline the controller supports.
  localparam int CG_MEM_MAX_RD_LATENCY = 2;

endpackage

// File: rtl/cg_sync_fifo.sv
// Synchronous FIFO with occupancy count, used as the read-response queue.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is dropped when full (callers guarantee it never is); pop ignored when empty.
// Ports: i_clk/i_rstn clock and async active-low reset; i_push/i_push_dat write side;
//        i_pop read side; o_empty, o_head_dat (zero when empty), o_count occupancy.
module cg_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head_dat,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (count_q == '0);
  assign do_push = i_push && (count_q != CW'(DEPTH));
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_dat;
  end

  assign o_head_dat = o_empty ? '0 : mem_q[rd_ptr_q];
  assign o_count    = count_q;

endmodule

// File: rtl/cg_sram_controller.sv
// Serialises read/write requests onto one single-port SRAM and returns read data in order.
// Latency: raddr handshake in T -> o_rdata_valid in T+RD_LATENCY+1; write lands at the end of its handshake cycle.
// Backpressure: reads stall on credit (issued-but-uncaptured + queued < RDQ_DEPTH); writes never wait on credit.
// Ports: i_clk/i_rstn; raddr channel (i_raddr_valid/o_raddr_ready/i_raddr);
//        rdata channel (o_rdata_valid/i_rdata_ready/o_rdata); write channel
//        (i_wdata_valid/o_wdata_ready/i_wen/i_waddr/i_wdata); SRAM pins (o_sram_*, i_sram_rdata).
module cg_sram_controller
  import cg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 1,
  parameter int RDQ_DEPTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_raddr_valid,
  output logic                  o_raddr_ready,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic                  o_rdata_valid,
  input  logic                  i_rdata_ready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_wdata_valid,
  output logic                  o_wdata_ready,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_sram_cs,
  output logic                  o_sram_we,
  output logic [DEPTH_LOG2-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  input  logic [DATA_WIDTH-1:0] i_sram_rdata
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int CW  = $clog2(RDQ_DEPTH + 1);

  if (RD_LATENCY < 1 || RD_LATENCY > CG_MEM_MAX_RD_LATENCY) begin : g_bad_rd_latency
    $error("cg_sram_controller: RD_LATENCY must be 1 or 2");
  end
  if (RDQ_DEPTH < 2) begin : g_bad_rdq_depth
    $error("cg_sram_controller: RDQ_DEPTH must be at least 2");
  end

  cg_mem_prio_e          prio_q, prio_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [CW-1:0]         rdq_count;
  logic                  rdq_empty;
  logic                  credit_ok, rd_gnt, wr_gnt, capture;

  // Byte-offset bits and address bits above the SRAM depth are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_raddr, i_waddr};

  // Registered counters only, so a pop this cycle frees its credit next cycle.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, rdq_count}) < (CW + 1)'(RDQ_DEPTH);

  // Readies are forced low while reset is asserted so every output reads 0 in reset.
  assign o_raddr_ready = i_rstn && credit_ok && !(i_wdata_valid && prio_q == CG_PRIO_WRITE);
  assign o_wdata_ready = i_rstn && !(i_raddr_valid && credit_ok && prio_q == CG_PRIO_READ);

  // The two readies are mutually exclusive whenever both valids are up.
  assign rd_gnt  = i_raddr_valid && o_raddr_ready;
  assign wr_gnt  = i_wdata_valid && o_wdata_ready;
  assign capture = rd_vld_q[RD_LATENCY-1];

  always_comb begin
    o_sram_cs    = 1'b0;
    o_sram_we    = 1'b0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (rd_gnt) begin
      o_sram_cs   = 1'b1;
      o_sram_addr = i_raddr[OFF +: DEPTH_LOG2];
    end else if (wr_gnt && i_wen) begin
      o_sram_cs    = 1'b1;
      o_sram_we    = 1'b1;
      o_sram_addr  = i_waddr[OFF +: DEPTH_LOG2];
      o_sram_wdata = i_wdata;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (rd_gnt)      prio_d = CG_PRIO_WRITE;
    else if (wr_gnt) prio_d = CG_PRIO_READ;
    rd_vld_d   = RD_LATENCY'({rd_vld_q, rd_gnt});
    inflight_d = inflight_q + CW'(rd_gnt) - CW'(capture);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prio_q     <= CG_PRIO_READ;
      inflight_q <= '0;
      rd_vld_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  cg_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RDQ_DEPTH)
  ) u_rdq (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_push     (capture),
    .i_push_dat (i_sram_rdata),
    .i_pop      (i_rdata_ready),
    .o_empty    (rdq_empty),
    .o_head_dat (o_rdata),
    .o_count    (rdq_count)
  );

  assign o_rdata_valid = !rdq_empty;

endmodule

// File: tb/tb_cg_sram_controller.sv
// Self-checking bench for cg_sram_controller with a behavioural 1-cycle SRAM.
// Latency: n/a.
// Backpressure: driven by the stimulus through i_rdata_ready.
module tb_cg_sram_controller;

  localparam int DW = 32;
  localparam int AW = 36;
  localparam int DL = 10;
  localparam int RL = 1;
  localparam int QD = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          raddr_valid, raddr_ready, rdata_valid, rdata_ready;
  logic          wdata_valid, wdata_ready, wen;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] rdata, wdata, sram_wdata, sram_rdata;
  logic          sram_cs, sram_we;
  logic [DL-1:0] sram_addr;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  cg_sram_controller #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH_LOG2 (DL),
    .RD_LATENCY (RL), .RDQ_DEPTH  (QD)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_raddr_valid (raddr_valid),
    .o_raddr_ready (raddr_ready),
    .i_raddr       (raddr),
    .o_rdata_valid (rdata_valid),
    .i_rdata_ready (rdata_ready),
    .o_rdata       (rdata),
    .i_wdata_valid (wdata_valid),
    .o_wdata_ready (wdata_ready),
    .i_wen         (wen),
    .i_waddr       (waddr),
    .i_wdata       (wdata),
    .o_sram_cs     (sram_cs),
    .o_sram_we     (sram_we),
    .o_sram_addr   (sram_addr),
    .o_sram_wdata  (sram_wdata),
    .i_sram_rdata  (sram_rdata)
  );

  // Single-port SRAM, read latency 1, holds its output between reads.
  logic [DW-1:0] mem [0:(1<<DL)-1];
  logic [DW-1:0] sram_rd_q = '0;
  always @(posedge clk) begin
    if (sram_cs && sram_we)  mem[sram_addr] <= sram_wdata;
    if (sram_cs && !sram_we) sram_rd_q <= mem[sram_addr];
  end
  assign sram_rdata = sram_rd_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted response is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rstn && rdata_valid && rdata_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata_unexpected: got 0x%0h with nothing outstanding at %0t", rdata, $time);
      end else begin
        chk("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    waddr = a; wdata = d; wen = 1'b1; wdata_valid = 1'b1;
    smp();
    chk("wr_ready", wdata_ready, 1);
    cyc();
    wdata_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DL-1:0] wa;
    wa = a[DL+1:2];
    raddr = a; raddr_valid = 1'b1;
    smp();
    chk("rd_ready", raddr_ready, 1);
    chk("rd_sram_addr", sram_addr, wa);
    exp_q.push_back(d);
    cyc();
    raddr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rdata_valid) && n < 20) begin
      cyc();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_valid", rdata_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc;
    raddr_valid = 0; wdata_valid = 0; rdata_ready = 1; wen = 0;
    raddr = '0; waddr = '0; wdata = '0;

    // Reset: all outputs low even with both requests up.
    #2;
    raddr_valid = 1; wdata_valid = 1; wen = 1;
    #1;
    chk("rst_raddr_ready", raddr_ready, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_sram_cs", sram_cs, 0);
    chk("rst_rdata", rdata, 0);
    raddr_valid = 0; wdata_valid = 0;
    cyc(); cyc();
    rstn = 1'b1;
    cyc();

    // Write then read the same address; check pins and latency.
    waddr = 'h40; wdata = 32'hDEADBEEF; wen = 1; wdata_valid = 1;
    smp();
    chk("t1_wr_ready", wdata_ready, 1);
    chk("t1_wr_cs", sram_cs, 1);
    chk("t1_wr_we", sram_we, 1);
    chk("t1_wr_addr", sram_addr, 'h10);
    chk("t1_wr_wdata", sram_wdata, 32'hDEADBEEF);
    cyc();
    wdata_valid = 0; raddr = 'h40; raddr_valid = 1;
    exp_q.push_back(32'hDEADBEEF);
    smp();
    chk("t1_rd_ready", raddr_ready, 1);
    chk("t1_rd_cs", sram_cs, 1);
    chk("t1_rd_we", sram_we, 0);
    chk("t1_rd_addr", sram_addr, 'h10);
    cyc();
    raddr_valid = 0;
    smp();
    chk("t1_valid_T1", rdata_valid, 0);
    cyc();
    smp();
    chk("t1_valid_T2", rdata_valid, 1);
    cyc();
    drain();

    // Credit limit with the response queue stalled.
    rdata_ready = 0;
    for (int n = 0; n < 3; n++) wr(AW'('h100 + 4 * n), 32'hA000_0000 + n);
    acc = 0;
    raddr = 'h100; raddr_valid = 1;
    for (int i = 0; i < 6; i++) begin
      smp();
      if (raddr_ready) begin
        exp_q.push_back(32'hA000_0000 + acc);
        acc++;
      end
      cyc();
      raddr = AW'('h100 + 4 * acc);
    end
    raddr_valid = 0;
    chk("t2_accepts", acc, QD);
    smp();
    chk("t2_hold_valid", rdata_valid, 1);
    chk("t2_hold_data0", rdata, 32'hA000_0000);
    cyc();
    smp();
    chk("t2_hold_data1", rdata, 32'hA000_0000);
    chk("t2_full_ready", raddr_ready, 0);
    cyc();
    rdata_ready = 1; raddr = 'h108; raddr_valid = 1;
    smp();
    chk("t2_ready_pop_cycle", raddr_ready, 0);
    cyc();
    smp();
    chk("t2_ready_after_pop", raddr_ready, 1);
    exp_q.push_back(32'hA000_0002);
    cyc();
    raddr_valid = 0;
    drain();

    // Contention: prio starts at READ after a lone write, then grants alternate.
    wr('h200, 32'hB000_0000);
    raddr = 'h200; raddr_valid = 1;
    waddr = 'h204; wen = 1; wdata_valid = 1;
    for (int i = 0; i < 6; i++) begin
      wdata = 32'hC000_0000 + i;
      smp();
      chk("t3_alt_r", raddr_ready, (i % 2 == 0) ? 1 : 0);
      chk("t3_alt_w", wdata_ready, (i % 2 == 1) ? 1 : 0);
      if (raddr_ready) exp_q.push_back(32'hB000_0000);
      cyc();
    end
    raddr_valid = 0; wdata_valid = 0;
    drain();
    chk("t3_last_write", mem[10'h081], 32'hC000_0005);

    // Write with i_wen=0 completes the handshake but leaves memory untouched.
    wr('h40, 32'h12345678);
    waddr = 'h40; wdata = 32'hFFFFFFFF; wen = 0; wdata_valid = 1;
    smp();
    chk("t4_nowen_ready", wdata_ready, 1);
    chk("t4_nowen_cs", sram_cs, 0);
    cyc();
    wdata_valid = 0; wen = 1;
    rd('h40, 32'h12345678);
    drain();

    // Upper address bits alias.
    rd(36'h1_0000_0040, 32'h12345678);
    drain();

    // Reset with two reads in flight: responses discarded.
    raddr = 'h40; raddr_valid = 1;
    smp();
    chk("t6_rd0_ready", raddr_ready, 1);
    cyc();
    raddr = 'h100;
    smp();
    chk("t6_rd1_ready", raddr_ready, 1);
    cyc();
    raddr_valid = 0; wdata_valid = 1;
    rstn = 1'b0;
    #1;
    chk("t6_rst_rdata_valid", rdata_valid, 0);
    chk("t6_rst_rdata", rdata, 0);
    chk("t6_rst_wdata_ready", wdata_ready, 0);
    chk("t6_rst_cs", sram_cs, 0);
    cyc();
    wdata_valid = 0;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t6_no_stale", rdata_valid, 0);
      cyc();
    end
    rd('h200, 32'hB000_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
